// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu,
// services mthi/mtlo and exposes HI/LO to mfhi/mflo through md_out.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                op_signed;

    logic                is_mul_op;
    logic                is_div_op;
    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] product;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   udiv_q;
    logic [DATA_W-1:0]   udiv_r;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;

    assign is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div_op = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign busy      = (state != IDLE);
    assign start     = (is_mul_op || is_div_op) && !busy;
    assign md_out    = hilo_sel ? hi : lo;

    // Arithmetic on latched operands only. Division works on magnitudes and then
    // restores signs; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    always_comb begin
        ext_a     = {(op_signed ? {DATA_W{op_a[DATA_W-1]}} : {DATA_W{1'b0}}), op_a};
        ext_b     = {(op_signed ? {DATA_W{op_b[DATA_W-1]}} : {DATA_W{1'b0}}), op_b};
        product   = ext_a * ext_b;
        neg_a     = op_signed && op_a[DATA_W-1];
        neg_b     = op_signed && op_b[DATA_W-1];
        mag_a     = neg_a ? (~op_a + DATA_W'(1)) : op_a;
        mag_b     = neg_b ? (~op_b + DATA_W'(1)) : op_b;
        udiv_q    = '0;
        udiv_r    = '0;
        if (mag_b != '0) begin
            udiv_q = mag_a / mag_b;
            udiv_r = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? (~udiv_q + DATA_W'(1)) : udiv_q;
        remainder = neg_a ? (~udiv_r + DATA_W'(1)) : udiv_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a      <= src_a;
                        op_b      <= src_b;
                        op_signed <= (md_op == OP_MULT) || (md_op == OP_DIV);
                        if (is_mul_op) begin
                            state <= MUL;
                            cnt   <= CNT_W'(MULT_CYCLES);
                        end else begin
                            state <= DIV;
                            cnt   <= CNT_W'(DIV_CYCLES);
                        end
                    end else if (md_op == OP_MTHI) begin
                        hi <= src_a;
                    end else if (md_op == OP_MTLO) begin
                        lo <= src_a;
                    end
                end
                MUL: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= product[2*DATA_W-1:DATA_W];
                        lo    <= product[DATA_W-1:0];
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    if (cnt == CNT_W'(1)) begin
                        // Divide by zero burns the full latency but leaves HI/LO alone.
                        if (op_b != '0) begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO and busy width,
// a monitor checks them when busy drops.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_width;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_sel;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hilo_sel (hilo_sel),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: measure each busy window and compare HI/LO when it closes.
    int   width = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            width++;
        end else if (prev_busy === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: busy window of %0d cycles with no expected entry", width);
            end else begin
                e = sb_q.pop_front();
                check("busy_width", 32'(width), 32'(e.exp_width));
                check("sb_hi", hi, e.exp_hi);
                check("sb_lo", lo, e.exp_lo);
                hilo_sel = 1'b1;
                #1 check("md_out_hi", md_out, e.exp_hi);
                hilo_sel = 1'b0;
                #1 check("md_out_lo", md_out, e.exp_lo);
            end
            width = 0;
        end
        prev_busy = busy;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
        end
    endtask

    // Drive one mult/div op in the first idle cycle; leaves us #1 into the next cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int w);
        exp_t e;
        wait_idle();
        md_op = op;
        src_a = a;
        src_b = b;
        e.exp_hi = ehi;
        e.exp_lo = elo;
        e.exp_width = w;
        sb_q.push_back(e);
        @(negedge clk);
        check("start_hi", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        md_op = 4'd0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        wait_idle();
        md_op = op;
        src_a = a;
        @(negedge clk);
        check("mt_no_start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        md_op = 4'd0;
    endtask

    initial begin
        reset    = 1'b1;
        md_op    = 4'd0;
        src_a    = '0;
        src_b    = '0;
        hilo_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1;

        // mult / multu
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);

        // div / divu, including the signed overflow corner
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

        // mthi / mtlo visible the next cycle, then divide by zero leaves them
        wait_idle();
        move_to(4'd5, 32'h1234_5678);
        check("mthi_hi", hi, 32'h1234_5678);
        move_to(4'd6, 32'h9ABC_DEF0);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mthi_kept", hi, 32'h1234_5678);
        issue(4'd3, 32'd55, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        // Inputs during a mult busy window are ignored
        issue(4'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5);
        md_op = 4'd6;
        src_a = 32'h0000_DEAD;
        src_b = 32'd7;
        @(negedge clk);
        check("busy_no_start_mt", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        md_op = 4'd1;
        src_a = 32'd100;
        src_b = 32'd100;
        @(negedge clk);
        check("busy_no_start_mul", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        md_op = 4'd0;

        // Reset in the 3rd busy cycle of a div aborts it
        issue(4'd3, 32'd100, 32'd7, 32'd0, 32'd0, 3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);

        // Back-to-back: second start lands in the first non-busy cycle
        issue(4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        issue(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers, executes mult/multu/div/divu as multi-cycle operations, and drives `busy` back to the hazard/stall unit. That unit freezes F/D whenever a mult/div-class instruction in D meets a busy unit or a start in E. It also services mthi/mtlo writes and supplies HI/LO to mfhi/mflo through the E-stage result path.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–31.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `md_op` in 4: E-stage operation.
  - 0 = none
  - 1 = mult
  - 2 = multu
  - 3 = div
  - 4 = divu
  - 5 = mthi
  - 6 = mtlo
  - 7–15 = treated as none
- `src_a` in 32: forwarded rs value; the dividend for div/divu.
- `src_b` in 32: forwarded rt value; the divisor for div/divu.
- `hilo_sel` in 1: selects the `md_out` source; 1 = HI (mfhi), 0 = LO (mflo).
- `start` out 1: combinational; high when `md_op` is 1–4 and `busy` is 0.
- `busy` out 1: registered; high while an operation is in flight.
- `hi` out 32: registered HI.
- `lo` out 32: registered LO.
- `md_out` out 32: combinational; `hilo_sel ? hi : lo`.

## Operation

State machine, states IDLE, MUL, DIV:
- IDLE → MUL: on `start` with `md_op` 1/2. Latch operands and signedness; load `cnt = MULT_CYCLES`.
- IDLE → DIV: on `start` with `md_op` 3/4. Latch operands and signedness; load `cnt = DIV_CYCLES`.
- In MUL or DIV, `cnt` decrements by 1 each cycle.
- On the edge where `cnt == 1`: write HI/LO, set `cnt = 0`, return to IDLE.
- `busy = (state != IDLE)`, decoded from registered state.

Arithmetic (64-bit product; results use the latched operands only):
- mult: `{HI,LO} = $signed(a) * $signed(b)`.
- multu: `{HI,LO} = a * b`, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- divu: LO = unsigned quotient; HI = unsigned remainder.
- Divisor zero (div/divu): the operation still occupies `DIV_CYCLES` with `busy` high. HI and LO are left unchanged.
- Overflow case div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.

mthi/mtlo:
- In IDLE, `md_op` 5 writes HI = `src_a` on the next edge; `md_op` 6 writes LO = `src_a`.
- Neither changes state or `busy`.

Ignored inputs:
- `md_op` 1–6 while `busy` is high: ignored; no operand latch, no HI/LO write. The stall unit guarantees this case does not arise; the unit must still be robust to it.
- `src_a`/`src_b` changing during MUL/DIV: no effect.

Reads:
- `md_out` reflects HI/LO combinationally in every state.
- During MUL/DIV, `md_out` shows the old values. Stalling mfhi/mflo is the stall unit's job.

Reset:
- `hi`, `lo` = 0; `busy` = 0; state = IDLE; `cnt` = 0; latched operands = 0.
- Reset asserted mid-operation aborts it: no HI/LO write, and the unit is in IDLE on the cycle after reset.
- Reset overrides a simultaneous `start`.

## Timing

- `start` high in cycle c:
  - `busy` is high in cycles c+1 … c+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy` is low, and new `hi`/`lo` are visible, in cycle c+N+1.
- Back-to-back: a new `start` is accepted in cycle c+N+1. That gives a minimum spacing of N+1 cycles between starts.
- mthi/mtlo in cycle c: new value visible on `hi`/`lo`/`md_out` in cycle c+1.
- `busy` is glitch-free: a register decode, with no combinational path from `md_op`.
- `start`→`busy` has exactly one cycle of latency. The stall unit covers cycle c itself by decoding the E-stage instruction.

## Test plan

1. Reset, then `md_op`=1 (mult), `src_a`=0xFFFFFFFF, `src_b`=2 → `busy` high exactly 5 cycles; afterwards `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. Repeat with multu → `hi`=0x00000001, `lo`=0xFFFFFFFE.
2. div with `src_a`=0xFFFFFFF9 (−7), `src_b`=2 → `busy` 10 cycles; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 7/2 → `lo`=3, `hi`=1.
3. mthi with `src_a`=0x12345678, then mtlo with `src_a`=0x9ABCDEF0 → `hi`/`lo` update one cycle after each. Then div by 0 → 10 busy cycles; `hi`/`lo` unchanged.
4. During a mult busy window, drive `md_op`=6 with `src_a`=0xDEAD and change `src_b` → final `lo` equals the original product's low word; `busy` width stays 5.
5. Assert `reset` in the 3rd busy cycle of a div → next cycle `busy`=0, `hi`=`lo`=0, and no later write occurs.
6. Back-to-back: multu 3×4 followed by a new `start` in the first non-busy cycle (divu 100/7) → `lo`=12, then `lo`=14, `hi`=2. `start` is high only in non-busy cycles.
